// File: rtl/mfpga_load_pkg.sv
// Shared constants, frame fields and FSM encoding for the slave-FPGA load
// report path (transmit side and the receive-side config controller).
package mfpga_load_pkg;

  localparam logic [7:0]  HDR_BYTE0     = 8'h55;
  localparam logic [7:0]  HDR_BYTE1     = 8'hAA;
  localparam logic [7:0]  TYPE_STATUS   = 8'h01;
  localparam logic [7:0]  TYPE_LOSS     = 8'h02;
  localparam logic [7:0]  LOSS_CODE     = 8'hEE;
  localparam logic [15:0] FRAME_LEN     = 16'd11;
  localparam logic [15:0] PAYLOAD_LEN   = 16'd4;
  localparam logic [3:0]  LAST_BYTE_IDX = 4'd10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_SEND = 2'd2,
    ST_DONE = 2'd3
  } load_state_e;

  typedef struct packed {
    logic [7:0]  frame_type;
    logic [7:0]  code;
    logic [15:0] pkg_total;
  } frame_fields_t;

  typedef struct packed {
    logic        pending;
    logic [7:0]  code;
    logic [15:0] pkg_total;
  } event_slot_t;

endpackage

// File: rtl/mfpga_load_report_tx_report_frame_mux.sv
// Combinational byte selector for the 11-byte load report frame; the
// checksum is the XOR of bytes 2-9 rebuilt from the latched fields.
module report_frame_mux
  import mfpga_load_pkg::*;
#(
  parameter logic [15:0] CMD_ID = 16'hA5C1
) (
  input  logic [3:0]    byte_idx_i,
  input  frame_fields_t fields_i,
  output logic [7:0]    byte_o
);

  logic [7:0] checksum;

  always_comb begin
    checksum = CMD_ID[15:8] ^ CMD_ID[7:0] ^ PAYLOAD_LEN[15:8] ^ PAYLOAD_LEN[7:0] ^
               fields_i.frame_type ^ fields_i.code ^
               fields_i.pkg_total[15:8] ^ fields_i.pkg_total[7:0];
    byte_o = 8'h00;
    case (byte_idx_i)
      4'd0:    byte_o = HDR_BYTE0;
      4'd1:    byte_o = HDR_BYTE1;
      4'd2:    byte_o = CMD_ID[15:8];
      4'd3:    byte_o = CMD_ID[7:0];
      4'd4:    byte_o = PAYLOAD_LEN[15:8];
      4'd5:    byte_o = PAYLOAD_LEN[7:0];
      4'd6:    byte_o = fields_i.frame_type;
      4'd7:    byte_o = fields_i.code;
      4'd8:    byte_o = fields_i.pkg_total[15:8];
      4'd9:    byte_o = fields_i.pkg_total[7:0];
      4'd10:   byte_o = checksum;
      default: byte_o = 8'h00;
    endcase
  end

endmodule

// File: rtl/mfpga_load_report_tx.sv
// Turns load-loss / load-status pulses into 11-byte UDP report frames and
// streams them to the UDP transmit engine via req/ack then valid/ready.
module mfpga_load_report_tx
  import mfpga_load_pkg::*;
#(
  parameter logic [15:0] CMD_ID      = 16'hA5C1,
  parameter logic [15:0] ACK_TIMEOUT = 16'd65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_loss_i,
  input  logic [8:0]  load_status_i,
  input  logic [15:0] pkg_total_i,
  output logic        udp_tx_req_o,
  input  logic        udp_tx_ack_i,
  output logic [15:0] udp_tx_len_o,
  output logic [7:0]  udp_tx_data_o,
  output logic        udp_tx_vld_o,
  input  logic        udp_tx_rdy_i,
  output logic        busy_o,
  output logic [7:0]  drop_cnt_o
);

  load_state_e   state_q, state_d;
  logic [3:0]    byte_idx_q, byte_idx_d;
  logic [15:0]   tmo_cnt_q, tmo_cnt_d;
  logic [7:0]    drop_cnt_q, drop_cnt_d;
  event_slot_t   loss_slot_q, loss_slot_d;
  event_slot_t   stat_slot_q, stat_slot_d;
  frame_fields_t frame_q, frame_d;

  logic       loss_clr, stat_clr;
  logic       tmo_drop, loss_ovr, stat_ovr;
  logic [1:0] drop_inc;
  logic [8:0] drop_sum;
  logic [7:0] mux_byte;

  report_frame_mux #(.CMD_ID(CMD_ID)) u_frame_mux (
    .byte_idx_i (byte_idx_q),
    .fields_i   (frame_q),
    .byte_o     (mux_byte)
  );

  always_comb begin
    state_d     = state_q;
    byte_idx_d  = byte_idx_q;
    tmo_cnt_d   = tmo_cnt_q;
    frame_d     = frame_q;
    loss_slot_d = loss_slot_q;
    stat_slot_d = stat_slot_q;
    loss_clr    = 1'b0;
    stat_clr    = 1'b0;
    tmo_drop    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (loss_slot_q.pending) begin
          frame_d   = '{frame_type: TYPE_LOSS, code: loss_slot_q.code,
                        pkg_total: loss_slot_q.pkg_total};
          loss_clr  = 1'b1;
          tmo_cnt_d = 16'd0;
          state_d   = ST_REQ;
        end else if (stat_slot_q.pending) begin
          frame_d   = '{frame_type: TYPE_STATUS, code: stat_slot_q.code,
                        pkg_total: stat_slot_q.pkg_total};
          stat_clr  = 1'b1;
          tmo_cnt_d = 16'd0;
          state_d   = ST_REQ;
        end
      end
      ST_REQ: begin
        if (udp_tx_ack_i) begin
          byte_idx_d = 4'd0;
          state_d    = ST_SEND;
        end else if (tmo_cnt_q >= ACK_TIMEOUT) begin
          tmo_drop = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 16'd1;
        end
      end
      ST_SEND: begin
        if (udp_tx_rdy_i) begin
          if (byte_idx_q == LAST_BYTE_IDX) begin
            state_d = ST_DONE;
          end else begin
            byte_idx_d = byte_idx_q + 4'd1;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // A slot taken for a frame this cycle is not an overrun; a set in the
    // same cycle as the clear wins so the new event is not lost.
    loss_ovr = load_loss_i && loss_slot_q.pending && !loss_clr;
    stat_ovr = load_status_i[8] && stat_slot_q.pending && !stat_clr;
    if (loss_clr) loss_slot_d.pending = 1'b0;
    if (stat_clr) stat_slot_d.pending = 1'b0;
    if (load_loss_i) begin
      loss_slot_d = '{pending: 1'b1, code: LOSS_CODE, pkg_total: pkg_total_i};
    end
    if (load_status_i[8]) begin
      stat_slot_d = '{pending: 1'b1, code: load_status_i[7:0], pkg_total: pkg_total_i};
    end

    drop_inc   = 2'(tmo_drop) + 2'(loss_ovr) + 2'(stat_ovr);
    drop_sum   = {1'b0, drop_cnt_q} + {7'd0, drop_inc};
    drop_cnt_d = drop_sum[8] ? 8'hFF : drop_sum[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      byte_idx_q  <= 4'd0;
      tmo_cnt_q   <= 16'd0;
      drop_cnt_q  <= 8'd0;
      loss_slot_q <= '0;
      stat_slot_q <= '0;
      frame_q     <= '0;
    end else begin
      state_q     <= state_d;
      byte_idx_q  <= byte_idx_d;
      tmo_cnt_q   <= tmo_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
      loss_slot_q <= loss_slot_d;
      stat_slot_q <= stat_slot_d;
      frame_q     <= frame_d;
    end
  end

  assign udp_tx_req_o  = (state_q == ST_REQ);
  assign udp_tx_vld_o  = (state_q == ST_SEND);
  assign udp_tx_data_o = udp_tx_vld_o ? mux_byte : 8'h00;
  assign udp_tx_len_o  = FRAME_LEN;
  assign busy_o        = (state_q != ST_IDLE) || loss_slot_q.pending || stat_slot_q.pending;
  assign drop_cnt_o    = drop_cnt_q;

endmodule

// File: tb/tb_mfpga_load_report_tx.sv
// Directed bench for mfpga_load_report_tx: table of single-event frames plus
// hand-written sequences for arbitration, timeout, overrun and reset.
module tb_mfpga_load_report_tx;

  localparam logic [15:0] TB_ACK_TIMEOUT = 16'd16;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_loss_i;
  logic [8:0]  load_status_i;
  logic [15:0] pkg_total_i;
  logic        udp_tx_req_o;
  logic        udp_tx_ack_i;
  logic [15:0] udp_tx_len_o;
  logic [7:0]  udp_tx_data_o;
  logic        udp_tx_vld_o;
  logic        udp_tx_rdy_i;
  logic        busy_o;
  logic [7:0]  drop_cnt_o;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_frame [11];

  typedef struct {
    bit          is_loss;
    logic [7:0]  st_code;
    logic [15:0] total;
    int          ack_delay;
    bit          toggle_rdy;
    logic [7:0]  exp_type;
    logic [7:0]  exp_code;
    logic [7:0]  exp_csum;
  } vec_t;

  vec_t vecs [4];

  always #5 clk = ~clk;

  mfpga_load_report_tx #(
    .CMD_ID      (16'hA5C1),
    .ACK_TIMEOUT (TB_ACK_TIMEOUT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .load_loss_i   (load_loss_i),
    .load_status_i (load_status_i),
    .pkg_total_i   (pkg_total_i),
    .udp_tx_req_o  (udp_tx_req_o),
    .udp_tx_ack_i  (udp_tx_ack_i),
    .udp_tx_len_o  (udp_tx_len_o),
    .udp_tx_data_o (udp_tx_data_o),
    .udp_tx_vld_o  (udp_tx_vld_o),
    .udp_tx_rdy_i  (udp_tx_rdy_i),
    .busy_o        (busy_o),
    .drop_cnt_o    (drop_cnt_o)
  );

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
    end
  endtask

  // Drives one event pulse at the current negedge and returns one cycle later.
  task automatic apply_stimulus(input bit loss, input bit stat,
                                input logic [7:0] code, input logic [15:0] total);
    load_loss_i   = loss;
    load_status_i = {stat, code};
    pkg_total_i   = total;
    @(negedge clk);
    load_loss_i   = 1'b0;
    load_status_i = 9'h000;
  endtask

  task automatic set_expected(input logic [7:0] typ, input logic [7:0] code,
                              input logic [15:0] total, input logic [7:0] csum);
    exp_frame[0]  = 8'h55;
    exp_frame[1]  = 8'hAA;
    exp_frame[2]  = 8'hA5;
    exp_frame[3]  = 8'hC1;
    exp_frame[4]  = 8'h00;
    exp_frame[5]  = 8'h04;
    exp_frame[6]  = typ;
    exp_frame[7]  = code;
    exp_frame[8]  = total[15:8];
    exp_frame[9]  = total[7:0];
    exp_frame[10] = csum;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Waits for req, acks after ack_delay extra REQ cycles, then receives and
  // checks all 11 bytes against exp_frame, ending on the DONE cycle.
  task automatic run_frame(input int ack_delay, input bit toggle_rdy, output int gap);
    int  n;
    int  idx;
    int  cyc;
    bit  rdy_now;
    n = 0;
    while (udp_tx_req_o !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    gap = n;
    check_output("req_seen", 32'(udp_tx_req_o), 32'd1);
    if (udp_tx_req_o !== 1'b1) return;
    for (int i = 0; i < ack_delay; i++) @(negedge clk);
    check_output("req_held", 32'(udp_tx_req_o), 32'd1);
    udp_tx_ack_i = 1'b1;
    @(negedge clk);
    udp_tx_ack_i = 1'b0;
    check_output("req_drop_after_ack", 32'(udp_tx_req_o), 32'd0);
    check_output("vld_after_ack", 32'(udp_tx_vld_o), 32'd1);
    idx = 0;
    cyc = 0;
    while (idx < 11 && cyc < 64) begin
      check_output("vld_continuous", 32'(udp_tx_vld_o), 32'd1);
      check_output($sformatf("byte%0d", idx), 32'(udp_tx_data_o), 32'(exp_frame[idx]));
      rdy_now = toggle_rdy ? cyc[0] : 1'b1;
      udp_tx_rdy_i = rdy_now;
      @(negedge clk);
      if (rdy_now) idx++;
      cyc++;
    end
    udp_tx_rdy_i = 1'b0;
    check_output("frame_complete", 32'(idx), 32'd11);
    check_output("done_vld_low", 32'(udp_tx_vld_o), 32'd0);
    check_output("done_req_low", 32'(udp_tx_req_o), 32'd0);
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int gap;
    int n;

    rst           = 1'b1;
    load_loss_i   = 1'b0;
    load_status_i = 9'h000;
    pkg_total_i   = 16'h0000;
    udp_tx_ack_i  = 1'b0;
    udp_tx_rdy_i  = 1'b0;

    // Checksum base: A5^C1^00^04 = 0x60, then XOR type, code, total bytes.
    vecs[0] = '{1'b0, 8'h01, 16'h0123, 3, 1'b0, 8'h01, 8'h01, 8'h42};
    vecs[1] = '{1'b1, 8'h00, 16'hBEEF, 0, 1'b0, 8'h02, 8'hEE, 8'hDD};
    vecs[2] = '{1'b0, 8'h00, 16'h0000, 1, 1'b1, 8'h01, 8'h00, 8'h61};
    vecs[3] = '{1'b0, 8'h7F, 16'hFFFF, 5, 1'b1, 8'h01, 8'h7F, 8'h1E};

    repeat (3) @(negedge clk);
    check_output("rst_req", 32'(udp_tx_req_o), 32'd0);
    check_output("rst_vld", 32'(udp_tx_vld_o), 32'd0);
    check_output("rst_data", 32'(udp_tx_data_o), 32'd0);
    check_output("rst_busy", 32'(busy_o), 32'd0);
    check_output("rst_drop", 32'(drop_cnt_o), 32'd0);
    check_output("rst_len", 32'(udp_tx_len_o), 32'd11);
    rst = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 4; v++) begin
      set_expected(vecs[v].exp_type, vecs[v].exp_code, vecs[v].total, vecs[v].exp_csum);
      apply_stimulus(vecs[v].is_loss, !vecs[v].is_loss, vecs[v].st_code, vecs[v].total);
      check_output("req_low_n1", 32'(udp_tx_req_o), 32'd0);
      check_output("busy_n1", 32'(busy_o), 32'd1);
      @(negedge clk);
      check_output("req_high_n2", 32'(udp_tx_req_o), 32'd1);
      run_frame(vecs[v].ack_delay, vecs[v].toggle_rdy, gap);
      repeat (3) @(negedge clk);
      check_output("vec_drop", 32'(drop_cnt_o), 32'd0);
    end

    $display("[TB] simultaneous loss and status events");
    set_expected(8'h02, 8'hEE, 16'h0010, 8'h9C);
    apply_stimulus(1'b1, 1'b1, 8'h00, 16'h0010);
    run_frame(2, 1'b0, gap);
    check_output("stat_still_pending", 32'(busy_o), 32'd1);
    set_expected(8'h01, 8'h00, 16'h0010, 8'h71);
    run_frame(1, 1'b0, gap);
    check_output("gap_at_least_2", 32'(gap >= 2), 32'd1);
    repeat (3) @(negedge clk);

    $display("[TB] ack timeout");
    apply_stimulus(1'b0, 1'b1, 8'h01, 16'h0001);
    n = 0;
    while (udp_tx_req_o !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (udp_tx_req_o === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    check_output("timeout_req_cycles", 32'(n), 32'd17);
    check_output("timeout_req_low", 32'(udp_tx_req_o), 32'd0);
    check_output("timeout_drop", 32'(drop_cnt_o), 32'd1);
    check_output("timeout_idle", 32'(busy_o), 32'd0);

    reset_dut();
    check_output("reset_clears_drop", 32'(drop_cnt_o), 32'd0);

    $display("[TB] overrun while request stalled");
    set_expected(8'h01, 8'h11, 16'h1111, 8'h70);
    apply_stimulus(1'b0, 1'b1, 8'h11, 16'h1111);
    @(negedge clk);
    check_output("ovr_req_high", 32'(udp_tx_req_o), 32'd1);
    apply_stimulus(1'b0, 1'b1, 8'h22, 16'h2222);
    apply_stimulus(1'b0, 1'b1, 8'h33, 16'h3333);
    check_output("overrun_drop", 32'(drop_cnt_o), 32'd1);
    run_frame(0, 1'b0, gap);
    set_expected(8'h01, 8'h33, 16'h3333, 8'h52);
    run_frame(0, 1'b0, gap);
    repeat (3) @(negedge clk);

    $display("[TB] drop counter saturation");
    for (int i = 0; i < 300; i++) begin
      load_status_i = {1'b1, 8'h44};
      pkg_total_i   = 16'h4444;
      @(negedge clk);
    end
    load_status_i = 9'h000;
    check_output("drop_saturated", 32'(drop_cnt_o), 32'hFF);
    n = 0;
    while (busy_o === 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_output("drain_idle", 32'(busy_o), 32'd0);
    check_output("drop_still_saturated", 32'(drop_cnt_o), 32'hFF);

    $display("[TB] reset in the middle of a frame");
    set_expected(8'h01, 8'h05, 16'h0505, 8'h64);
    apply_stimulus(1'b0, 1'b1, 8'h05, 16'h0505);
    n = 0;
    while (udp_tx_req_o !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    udp_tx_ack_i = 1'b1;
    @(negedge clk);
    udp_tx_ack_i = 1'b0;
    udp_tx_rdy_i = 1'b1;
    repeat (5) @(negedge clk);
    check_output("byte5_before_reset", 32'(udp_tx_data_o), 32'(exp_frame[5]));
    rst = 1'b1;
    @(negedge clk);
    check_output("midrst_vld", 32'(udp_tx_vld_o), 32'd0);
    check_output("midrst_req", 32'(udp_tx_req_o), 32'd0);
    check_output("midrst_busy", 32'(busy_o), 32'd0);
    check_output("midrst_drop", 32'(drop_cnt_o), 32'd0);
    rst = 1'b0;
    udp_tx_rdy_i = 1'b0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (udp_tx_req_o === 1'b1 || udp_tx_vld_o === 1'b1) n++;
    end
    check_output("no_resume", 32'(n), 32'd0);
    check_output("len_const", 32'(udp_tx_len_o), 32'd11);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
